// File: rtl/ext_tran_pkg.sv
// ext_tran_pkg: size encodings, FSM states and host-bridge control bits shared by both ends of the external transaction link
package ext_tran_pkg;
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;
  typedef enum logic [1:0] {IDLE = 2'b00, BUS = 2'b01, DONE = 2'b10} state_e;
  localparam int CPU_RESET      = 0;
  localparam int EXT_MASTER_EN  = 1;
  localparam int TRAN_START     = 2;
  localparam int TRAN_WRITE     = 3;
  localparam int TRAN_CLEAR     = 4;
  localparam int TRAN_SIZE_LOW  = 5;
  localparam int TRAN_SIZE_HIGH = 6;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    return size == SIZE_RSVD || (size == SIZE_HALF && lane[0]) || (size == SIZE_WORD && lane != 2'b00);
  endfunction
endpackage

// File: rtl/ext_tran_lane.sv
// ext_tran_lane: byte-enable and lane-replicated write data generation plus right-aligned read extraction
module ext_tran_lane
  import ext_tran_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lane_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  sel_o,
  output logic [31:0] wdat_o,
  output logic [31:0] rdata_o
);
  logic [31:0] shifted;
  always_comb begin
    shifted = rdata_i >> {lane_i, 3'b000};
    sel_o   = size_i == SIZE_BYTE ? 4'b0001 << lane_i :
              size_i == SIZE_HALF ? (lane_i[1] ? 4'b1100 : 4'b0011) :
              size_i == SIZE_WORD ? 4'b1111 : 4'b0000;
    wdat_o  = size_i == SIZE_BYTE ? {4{wdata_i[7:0]}} :
              size_i == SIZE_HALF ? {2{wdata_i[15:0]}} : wdata_i;
    rdata_o = size_i == SIZE_BYTE ? {24'b0, shifted[7:0]} :
              size_i == SIZE_HALF ? {16'b0, shifted[15:0]} : rdata_i;
  end
endmodule

// File: rtl/ext_tran_master.sv
// ext_tran_master: one host start pulse -> one Wishbone classic cycle with sticky ready/error; EXT_TRAN_TIMEOUT_EN adds an ack timeout abort
module ext_tran_master
  import ext_tran_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [ADDR_WIDTH-1:0] ext_tran_addr_i,
  input  logic [31:0]           ext_tran_data_i,
  input  logic [1:0]            ext_tran_size_i,
  input  logic                  ext_tran_write_i,
  input  logic                  ext_tran_start_i,
  input  logic                  ext_tran_clear_i,
  output logic [31:0]           ext_tran_data_o,
  output logic                  ext_tran_ready_o,
  output logic                  ext_tran_error_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [31:0]           wb_dat_o,
  input  logic [31:0]           wb_dat_i,
  output logic [3:0]            wb_sel_o,
  output logic                  wb_we_o,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  input  logic                  wb_ack_i,
  input  logic                  wb_err_i
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] adr_q, adr_d;
  logic [31:0]           wdat_q, wdat_d, data_q, data_d;
  logic [3:0]            sel_q, sel_d;
  logic [1:0]            size_q, size_d, lane_q, lane_d;
  logic                  we_q, we_d, cyc_q, cyc_d, ready_q, ready_d, error_q, error_d;
  logic                  start_ok, bad, resp, timeout;
  logic [1:0]            lsize, llane;
  logic [3:0]            lsel;
  logic [31:0]           lwdat, lrdata;
  assign start_ok = ext_tran_start_i & enable_i;
  assign bad      = misaligned(ext_tran_size_i, ext_tran_addr_i[1:0]);
  assign resp     = wb_ack_i | wb_err_i;
  assign lsize    = state_q == IDLE ? ext_tran_size_i : size_q;
  assign llane    = state_q == IDLE ? ext_tran_addr_i[1:0] : lane_q;
  ext_tran_lane u_lane (
    .size_i  (lsize),
    .lane_i  (llane),
    .wdata_i (ext_tran_data_i),
    .rdata_i (wb_dat_i),
    .sel_o   (lsel),
    .wdat_o  (lwdat),
    .rdata_o (lrdata)
  );
`ifdef EXT_TRAN_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 2 ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign cnt_d   = state_q == BUS ? cnt_q + 1'b1 : '0;
  assign timeout = state_q == BUS && cnt_q == CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk_i) cnt_q <= !reset_i ? '0 : cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES != 0;
  assign timeout        = 1'b0;
`endif
  always_ff @(posedge clk_i) state_q <= !reset_i ? IDLE : state_d;
  always_comb begin
    state_d = state_q == IDLE ? (start_ok ? (bad ? DONE : BUS) : IDLE) :
              state_q == BUS  ? (resp | timeout ? DONE : BUS) :
              (ext_tran_clear_i ? IDLE : DONE);
  end
  always_comb begin
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    data_d  = data_q;
    sel_d   = sel_q;
    size_d  = size_q;
    lane_d  = lane_q;
    we_d    = we_q;
    cyc_d   = cyc_q;
    ready_d = ready_q;
    error_d = error_q;
    if (state_q == IDLE && start_ok) begin
      size_d = ext_tran_size_i;
      lane_d = ext_tran_addr_i[1:0];
      if (bad) begin
        ready_d = 1'b1;
        error_d = 1'b1;
        data_d  = '0;
      end else begin
        cyc_d  = 1'b1;
        we_d   = ext_tran_write_i;
        sel_d  = lsel;
        wdat_d = lwdat;
        adr_d  = {ext_tran_addr_i[ADDR_WIDTH-1:2], 2'b00};
      end
    end
    if (state_q == BUS && (resp | timeout)) begin
      cyc_d   = 1'b0;
      we_d    = 1'b0;
      sel_d   = '0;
      ready_d = 1'b1;
      error_d = wb_err_i | ~resp;
      data_d  = resp & ~wb_err_i & ~we_q ? lrdata : '0;
    end
    if (state_q == DONE && ext_tran_clear_i) begin
      ready_d = 1'b0;
      error_d = 1'b0;
      data_d  = '0;
    end
  end
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      adr_q   <= '0;
      wdat_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      size_q  <= '0;
      lane_q  <= '0;
      we_q    <= 1'b0;
      cyc_q   <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      size_q  <= size_d;
      lane_q  <= lane_d;
      we_q    <= we_d;
      cyc_q   <= cyc_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end
  assign ext_tran_data_o  = data_q;
  assign ext_tran_ready_o = ready_q;
  assign ext_tran_error_o = error_q;
  assign wb_adr_o         = adr_q;
  assign wb_dat_o         = wdat_q;
  assign wb_sel_o         = sel_q;
  assign wb_we_o          = we_q;
  assign wb_cyc_o         = cyc_q;
  assign wb_stb_o         = cyc_q;
endmodule
